multi_channel_timer: RTL

Parametrised bank of independent interval timers driven from one shared prescaled tick. It generalises the single free-running wrap counter used today into N channels. Each channel has:
- a run-time programmable terminal count,
- one-shot or periodic mode,
- start/stop control,
- a one-cycle expiry pulse.

In the elevator controller it serves the door-open dwell, floor-travel timeout and request-debounce timers from a single block.

---
 rtl/timer_pkg.sv | 18 +
 rtl/tick_divider.sv | 40 ++++
 rtl/multi_channel_timer.sv | 133 +++++++++++++
 3 files changed

// File: rtl/timer_pkg.sv
// -----------------------------------------------------------------------------
// timer_pkg
// Shared types and constants for the multi-channel interval timer.
//   timer_state_t  : per-channel FSM state (IDLE, RUN)
//   MODE_ONESHOT   : channel returns to IDLE after its first expiry
//   MODE_PERIODIC  : channel reloads and keeps running after each expiry
// -----------------------------------------------------------------------------
package timer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } timer_state_t;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

endpackage : timer_pkg

// File: rtl/tick_divider.sv
// -----------------------------------------------------------------------------
// tick_divider
// Free-running prescaler shared by all timer channels. Counts 0..PRESCALE-1
// from reset and raises tick during the cycle in which it holds PRESCALE-1.
//
// Parameters:
//   PRESCALE : clk cycles per tick (>=1; 1 = tick every cycle)
// Ports:
//   clk  in  system clock, rising edge
//   rst  in  asynchronous active-high reset
//   tick out one-cycle tick strobe
// -----------------------------------------------------------------------------
module tick_divider #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  // A one-bit counter is kept for PRESCALE=1; it simply stays at zero,
  // which makes tick permanently high.
  localparam int            CW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign tick = (r_cnt == LAST);

endmodule : tick_divider

// File: rtl/multi_channel_timer.sv
// -----------------------------------------------------------------------------
// multi_channel_timer
// Bank of CHANNELS independent interval timers sharing one prescaled tick.
// Each channel latches a terminal count and a mode on start, counts ticks
// from 0 up to the terminal count, and emits a one-cycle done pulse when a
// tick arrives while the count equals the terminal count.
//
// Parameters:
//   CHANNELS : number of timer channels (>=1)
//   WIDTH    : counter / period width per channel (>=1)
//   PRESCALE : clk cycles per timer tick (>=1)
// Ports:
//   clk    in  system clock, rising edge
//   rst    in  asynchronous active-high reset
//   start  in  [CHANNELS]        per-channel start/restart strobe
//   stop   in  [CHANNELS]        per-channel abort strobe (wins over start)
//   mode   in  [CHANNELS]        0 = one-shot, 1 = periodic (sampled on start)
//   period in  [CHANNELS*WIDTH]  terminal count, channel i at [i*WIDTH +: WIDTH]
//   count  out [CHANNELS*WIDTH]  current count per channel
//   busy   out [CHANNELS]        channel is in RUN
//   done   out [CHANNELS]        one-cycle expiry pulse
// -----------------------------------------------------------------------------
module multi_channel_timer
  import timer_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 16,
  parameter int PRESCALE = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS-1:0]       start,
  input  logic [CHANNELS-1:0]       stop,
  input  logic [CHANNELS-1:0]       mode,
  input  logic [CHANNELS*WIDTH-1:0] period,
  output logic [CHANNELS*WIDTH-1:0] count,
  output logic [CHANNELS-1:0]       busy,
  output logic [CHANNELS-1:0]       done
);

  logic w_tick;

  tick_divider #(
    .PRESCALE(PRESCALE)
  ) u_tick_divider (
    .clk (clk),
    .rst (rst),
    .tick(w_tick)
  );

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
      timer_state_t     r_state,  w_state_next;
      logic [WIDTH-1:0] r_count,  w_count_next;
      logic [WIDTH-1:0] r_period, w_period_next;
      logic             r_mode,   w_mode_next;
      logic             r_done,   w_done_next;
      logic [WIDTH-1:0] w_period_in;

      assign w_period_in = period[gi*WIDTH +: WIDTH];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_state  <= IDLE;
          r_count  <= '0;
          r_period <= '0;
          r_mode   <= MODE_ONESHOT;
          r_done   <= 1'b0;
        end else begin
          r_state  <= w_state_next;
          r_count  <= w_count_next;
          r_period <= w_period_next;
          r_mode   <= w_mode_next;
          r_done   <= w_done_next;
        end
      end

      always_comb begin
        w_state_next  = r_state;
        w_count_next  = r_count;
        w_period_next = r_period;
        w_mode_next   = r_mode;
        w_done_next   = 1'b0;

        unique case (r_state)
          IDLE: begin
            // A simultaneous stop suppresses the start, so the channel
            // stays idle.
            if (start[gi] && !stop[gi]) begin
              w_period_next = w_period_in;
              w_mode_next   = mode[gi];
              w_count_next  = '0;
              w_state_next  = RUN;
            end
          end

          RUN: begin
            if (stop[gi]) begin
              w_count_next = '0;
              w_state_next = IDLE;
            end else if (start[gi]) begin
              // Restart swallows any tick landing in the same cycle.
              w_period_next = w_period_in;
              w_mode_next   = mode[gi];
              w_count_next  = '0;
            end else if (w_tick) begin
              if (r_count == r_period) begin
                w_done_next  = 1'b1;
                w_count_next = '0;
                if (r_mode != MODE_PERIODIC) begin
                  w_state_next = IDLE;
                end
              end else begin
                // count never passes r_period, so this cannot wrap.
                w_count_next = r_count + WIDTH'(1);
              end
            end
          end

          default: begin
            w_state_next = IDLE;
          end
        endcase
      end

      assign count[gi*WIDTH +: WIDTH] = r_count;
      assign busy[gi]                 = (r_state == RUN);
      assign done[gi]                 = r_done;
    end
  endgenerate

endmodule : multi_channel_timer
